// File: rtl/arm_mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_mac_seq_pkg
// Brief    : Shared mode-bit positions and state encodings for the MAC unit.
// Revision : 1.0
// ============================================================================
package arm_mac_seq_pkg;

   // mode = {long, signed, accumulate}; decode builds it from instruction bits 23:21
   localparam int unsigned c_MAC_LONG   = 2;
   localparam int unsigned c_MAC_SIGNED = 1;
   localparam int unsigned c_MAC_ACC    = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } mac_state_t;

endpackage
`default_nettype wire

// File: rtl/arm_mac_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : arm_mac_seq_if
// Brief    : Start/busy/done request and result bundle between decode and MAC.
// Revision : 1.0
// ============================================================================
interface arm_mac_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       mode;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] acc_hi;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             flag_n;
   logic             flag_z;

   modport master (
      output start, mode, op_a, op_b, acc_lo, acc_hi,
      input  busy, done, result_lo, result_hi, flag_n, flag_z
   );

   modport slave (
      input  start, mode, op_a, op_b, acc_lo, acc_hi,
      output busy, done, result_lo, result_hi, flag_n, flag_z
   );
endinterface
`default_nettype wire

// File: rtl/arm_mac_seq_step.sv
`default_nettype none
// ============================================================================
// Module   : arm_mac_seq_step
// Brief    : One iteration: STEP x WIDTH partial product, shifted into the
//            2*WIDTH running product.
// Revision : 1.0
// ============================================================================
module arm_mac_seq_step #(
   parameter int WIDTH = 32,
   parameter int STEP  = 8,
   parameter int SH_W  = $clog2(2*WIDTH)
) (
   input  wire logic [2*WIDTH-1:0] i_prod,
   input  wire logic [WIDTH-1:0]   i_mcand,
   input  wire logic [STEP-1:0]    i_digit,
   input  wire logic [SH_W-1:0]    i_shift,
   output      logic [2*WIDTH-1:0] o_prod
);

   logic [WIDTH+STEP-1:0] w_pp;
   logic [2*WIDTH-1:0]    w_pp_ext;

   assign w_pp     = (WIDTH+STEP)'(i_mcand) * (WIDTH+STEP)'(i_digit);
   assign w_pp_ext = (2*WIDTH)'(w_pp) << i_shift;
   assign o_prod   = i_prod + w_pp_ext;

endmodule
`default_nettype wire

// File: rtl/arm_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : arm_mac_seq
// Brief    : Iterative MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit retiring STEP
//            multiplier bits per cycle with early termination.
// Revision : 1.0
// ============================================================================
module arm_mac_seq
   import arm_mac_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 8
) (
   input wire logic     clk,
   input wire logic     rst_n,
   arm_mac_seq_if.slave io_mac
);

   localparam int NCHUNK = WIDTH / STEP;
   localparam int CNT_W  = $clog2(NCHUNK + 1);
   localparam int SH_W   = $clog2(2*WIDTH);

   mac_state_t r_state, w_state_nxt;
   logic       w_latch, w_run, w_fin;

   logic [WIDTH-1:0]   r_mcand, r_mplier;
   logic [2*WIDTH-1:0] r_prod, r_acc;
   logic [CNT_W-1:0]   r_count;
   logic               r_neg, r_long;
   logic               r_done, r_flag_n, r_flag_z;
   logic [WIDTH-1:0]   r_res_lo, r_res_hi;

   logic               w_sgn;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_mplier_nxt;
   logic [CNT_W-1:0]   w_count_nxt;
   logic [SH_W-1:0]    w_shift;
   logic               w_last;
   logic [2*WIDTH-1:0] w_prod_step, w_prod_fix, w_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_run       = 1'b0;
      w_fin       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (io_mac.start) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_run = 1'b1;
            if (w_last) w_state_nxt = ST_FIN;
         end
         ST_FIN: begin
            w_fin       = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Signed long ops iterate on magnitudes; the product sign is restored in FIN
   assign w_sgn   = io_mac.mode[c_MAC_LONG] & io_mac.mode[c_MAC_SIGNED];
   assign w_a_mag = (w_sgn && io_mac.op_a[WIDTH-1]) ? -io_mac.op_a : io_mac.op_a;
   assign w_b_mag = (w_sgn && io_mac.op_b[WIDTH-1]) ? -io_mac.op_b : io_mac.op_b;

   assign w_mplier_nxt = r_mplier >> STEP;
   assign w_count_nxt  = r_count + CNT_W'(1);
   assign w_shift      = SH_W'(r_count) * SH_W'(STEP);
   assign w_last       = (w_count_nxt == CNT_W'(NCHUNK)) || (w_mplier_nxt == '0);

   arm_mac_seq_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .SH_W  (SH_W)
   ) u_step (
      .i_prod  (r_prod),
      .i_mcand (r_mcand),
      .i_digit (r_mplier[STEP-1:0]),
      .i_shift (w_shift),
      .o_prod  (w_prod_step)
   );

   // Short ops keep acc high half zero, so the low half of w_sum is mod 2^WIDTH
   assign w_prod_fix = r_neg ? -r_prod : r_prod;
   assign w_sum      = w_prod_fix + r_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         r_neg    <= 1'b0;
         r_long   <= 1'b0;
         r_done   <= 1'b0;
         r_res_lo <= '0;
         r_res_hi <= '0;
         r_flag_n <= 1'b0;
         r_flag_z <= 1'b0;
      end else begin
         r_done <= w_fin;
         if (w_latch) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_prod   <= '0;
            r_count  <= '0;
            r_neg    <= w_sgn & (io_mac.op_a[WIDTH-1] ^ io_mac.op_b[WIDTH-1]);
            r_long   <= io_mac.mode[c_MAC_LONG];
            if (!io_mac.mode[c_MAC_ACC])
               r_acc <= '0;
            else if (io_mac.mode[c_MAC_LONG])
               r_acc <= {io_mac.acc_hi, io_mac.acc_lo};
            else
               r_acc <= {{WIDTH{1'b0}}, io_mac.acc_lo};
         end
         if (w_run) begin
            r_prod   <= w_prod_step;
            r_mplier <= w_mplier_nxt;
            r_count  <= w_count_nxt;
         end
         if (w_fin) begin
            r_res_lo <= w_sum[WIDTH-1:0];
            r_res_hi <= r_long ? w_sum[2*WIDTH-1:WIDTH] : '0;
            r_flag_n <= r_long ? w_sum[2*WIDTH-1] : w_sum[WIDTH-1];
            r_flag_z <= r_long ? (w_sum == '0) : (w_sum[WIDTH-1:0] == '0);
         end
      end
   end

   assign io_mac.busy      = (r_state != ST_IDLE);
   assign io_mac.done      = r_done;
   assign io_mac.result_lo = r_res_lo;
   assign io_mac.result_hi = r_res_hi;
   assign io_mac.flag_n    = r_flag_n;
   assign io_mac.flag_z    = r_flag_z;

endmodule
`default_nettype wire

// File: tb/tb_arm_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_mac_seq
// Brief    : Scoreboard bench for arm_mac_seq at STEP = 8, 1, 4 and 32.
// Revision : 1.0
// ============================================================================
module tb_arm_mac_seq;

   localparam int W    = 32;
   localparam int NDUT = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          start;
   logic [2:0]    mode;
   logic [W-1:0]  op_a, op_b, acc_lo, acc_hi;

   logic [NDUT-1:0] d_busy, d_done, d_fn, d_fz;
   logic [W-1:0]    d_lo [NDUT];
   logic [W-1:0]    d_hi [NDUT];

   function automatic int step_of(input int i);
      case (i)
         0:       return 8;
         1:       return 1;
         2:       return 4;
         default: return 32;
      endcase
   endfunction

   generate
      for (genvar g = 0; g < NDUT; g++) begin : g_dut
         localparam int STEP_G = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
         arm_mac_seq_if #(.WIDTH(W)) u_if ();
         assign u_if.start  = start;
         assign u_if.mode   = mode;
         assign u_if.op_a   = op_a;
         assign u_if.op_b   = op_b;
         assign u_if.acc_lo = acc_lo;
         assign u_if.acc_hi = acc_hi;
         assign d_busy[g]   = u_if.busy;
         assign d_done[g]   = u_if.done;
         assign d_fn[g]     = u_if.flag_n;
         assign d_fz[g]     = u_if.flag_z;
         assign d_lo[g]     = u_if.result_lo;
         assign d_hi[g]     = u_if.result_hi;
         arm_mac_seq #(.WIDTH(W), .STEP(STEP_G)) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .io_mac (u_if)
         );
      end
   endgenerate

   typedef struct {
      int          dut;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        n;
      logic        z;
   } exp_t;

   exp_t        sb[$];
   int          free_at [NDUT];
   logic [31:0] last_lo [NDUT];
   logic [31:0] last_hi [NDUT];
   logic        last_n  [NDUT];
   logic        last_z  [NDUT];
   int          cyc      = 0;
   int          n_tests  = 0;
   int          n_fail   = 0;
   bit          fin_req  = 1'b0;

   // Architectural result from plain integer arithmetic
   function automatic exp_t model(input int dut, input logic [2:0] m,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] al, input logic [31:0] ah);
      exp_t        e;
      logic [63:0] p;
      logic [63:0] r;
      logic [31:0] s;
      if (m[2] && m[1]) p = longint'($signed(a)) * longint'($signed(b));
      else              p = {32'd0, a} * {32'd0, b};
      e.dut = dut;
      if (m[2]) begin
         r    = p + (m[0] ? {ah, al} : 64'd0);
         e.lo = r[31:0];
         e.hi = r[63:32];
         e.n  = r[63];
         e.z  = (r == 64'd0);
      end else begin
         s    = p[31:0] + (m[0] ? al : 32'd0);
         e.lo = s;
         e.hi = 32'd0;
         e.n  = s[31];
         e.z  = (s == 32'd0);
      end
      return e;
   endfunction

   // Number of STEP-bit chunks up to the highest set bit of the iterated multiplier
   function automatic int calc_k(input logic [2:0] m, input logic [31:0] b, input int step);
      logic [31:0] mag;
      int          hb;
      int          k;
      mag = (m[2] && m[1] && b[31]) ? -b : b;
      hb  = 0;
      for (int j = 0; j < 32; j++) if (mag[j]) hb = j + 1;
      k = (hb + step - 1) / step;
      return (k < 1) ? 1 : k;
   endfunction

   task automatic check(input string name, input int dut, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d(STEP=%0d) cycle %0d: got %0h, expected %0h",
                  name, dut, step_of(dut), cyc, act, exp);
      end
   endtask

   // Monitor: compares every cycle against the model, then books any new acceptance
   always @(negedge clk) begin
      int idx;
      cyc++;
      if (!rst_n) begin
         for (int i = 0; i < NDUT; i++) begin
            check("reset_ctl", i, 64'({d_busy[i], d_done[i], d_fn[i], d_fz[i]}), 64'd0);
            check("reset_res", i, {d_hi[i], d_lo[i]}, 64'd0);
            free_at[i] = 0;
            last_lo[i] = '0;
            last_hi[i] = '0;
            last_n[i]  = 1'b0;
            last_z[i]  = 1'b0;
         end
         sb.delete();
      end else begin
         for (int i = 0; i < NDUT; i++) begin
            check("busy", i, 64'(d_busy[i]), 64'(cyc < free_at[i] - 1));
            check("done", i, 64'(d_done[i]), 64'(cyc == free_at[i] - 1));
            if (cyc == free_at[i] - 1) begin
               idx = -1;
               for (int j = 0; j < sb.size(); j++)
                  if (idx < 0 && sb[j].dut == i) idx = j;
               check("sb_entry", i, 64'(idx >= 0), 64'd1);
               if (idx >= 0) begin
                  last_lo[i] = sb[idx].lo;
                  last_hi[i] = sb[idx].hi;
                  last_n[i]  = sb[idx].n;
                  last_z[i]  = sb[idx].z;
                  sb.delete(idx);
               end
            end
            check("result", i, {d_hi[i], d_lo[i]}, {last_hi[i], last_lo[i]});
            check("flags_nz", i, 64'({d_fn[i], d_fz[i]}), 64'({last_n[i], last_z[i]}));
         end
         if (start) begin
            for (int i = 0; i < NDUT; i++) begin
               if (cyc + 1 >= free_at[i]) begin
                  sb.push_back(model(i, mode, op_a, op_b, acc_lo, acc_hi));
                  free_at[i] = cyc + 1 + calc_k(mode, op_b, step_of(i)) + 2;
               end
            end
         end
      end
      if (fin_req || cyc > 30000) begin
         check("completed", 0, 64'(fin_req), 64'd1);
         check("sb_drained", 0, 64'(sb.size()), 64'd0);
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
   end

   function automatic bit all_free();
      for (int i = 0; i < NDUT; i++)
         if (cyc + 2 < free_at[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_idle();
      for (int t = 0; t < 200; t++) begin
         if (all_free()) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic issue(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] al, input logic [31:0] ah);
      @(posedge clk); #1;
      mode   = m;
      op_a   = a;
      op_b   = b;
      acc_lo = al;
      acc_hi = ah;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 255));
         default: return $urandom >> $urandom_range(0, 31);
      endcase
   endfunction

   initial begin
      logic [2:0]  m_a, m_b;
      logic [31:0] a_a, b_a, a_b, b_b;
      rst_n  = 1'b0;
      start  = 1'b0;
      mode   = 3'b000;
      op_a   = '0;
      op_b   = '0;
      acc_lo = '0;
      acc_hi = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      issue(3'b000, 32'd7, 32'd6, 32'd0, 32'd0);                         wait_idle();
      issue(3'b110, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd0);         wait_idle();
      issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF); wait_idle();
      issue(3'b001, 32'd0, 32'd0, 32'd0, 32'd0);                         wait_idle();
      issue(3'b000, 32'd5, 32'h100, 32'd0, 32'd0);                       wait_idle();
      issue(3'b111, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0);         wait_idle();
      issue(3'b110, 32'd3, 32'hFFFF_FFFB, 32'd0, 32'd0);                 wait_idle();
      issue(3'b011, 32'hFFFF_FFFF, 32'd9, 32'd9, 32'hDEAD_BEEF);         wait_idle();

      // Abort two cycles into RUN, then a fresh operation
      issue(3'b100, 32'h1234_5678, 32'hFFFF_FFFF, 32'd0, 32'd0);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      issue(3'b000, 32'd11, 32'd13, 32'd0, 32'd0);                       wait_idle();

      // start held high with two alternating operand sets
      m_a = 3'($urandom); a_a = rnd_op(); b_a = rnd_op();
      m_b = 3'($urandom); a_b = rnd_op(); b_b = rnd_op();
      for (int c = 0; c < 120; c++) begin
         @(posedge clk); #1;
         start  = 1'b1;
         mode   = c[0] ? m_a : m_b;
         op_a   = c[0] ? a_a : a_b;
         op_b   = c[0] ? b_a : b_b;
         acc_lo = c[0] ? 32'h0000_0003 : 32'hFFFF_FFF0;
         acc_hi = c[0] ? 32'h7FFF_FFFF : 32'h0000_0001;
      end
      @(posedge clk); #1 start = 1'b0;
      wait_idle();

      // Random traffic; operands change every cycle, including while busy
      for (int c = 0; c < 500; c++) begin
         @(posedge clk); #1;
         start  = ($urandom_range(0, 3) != 0);
         mode   = 3'($urandom);
         op_a   = rnd_op();
         op_b   = rnd_op();
         acc_lo = rnd_op();
         acc_hi = rnd_op();
      end
      @(posedge clk); #1 start = 1'b0;
      wait_idle();
      repeat (3) @(posedge clk);
      fin_req = 1'b1;
      repeat (5) @(posedge clk);
      $display("FAIL end_of_test: monitor did not close the run");
      $fatal(1);
   end

endmodule
`default_nettype wire
